// File: rtl/switch_pkg.sv
// Shared constants, types and the round-robin scan helper for the switch crossbar arbiter.
package switch_pkg;

   localparam int unsigned SWITCH_MAX_PORTS  = 16;
   localparam int unsigned SWITCH_IDX_W      = 4;
   localparam int unsigned SWITCH_DEF_PORTS  = 4;
   localparam int unsigned SWITCH_DEF_DATA_W = 16;
   localparam int unsigned SWITCH_DEF_CNT_W  = 16;

   typedef logic [SWITCH_IDX_W-1:0] src_idx_t;

   typedef struct packed {
      logic     found;
      src_idx_t idx;
   } rr_pick_t;

   // First set candidate strictly after 'last', wrapping modulo n (n <= SWITCH_MAX_PORTS).
   function automatic rr_pick_t rr_scan(input logic [SWITCH_MAX_PORTS-1:0] cand,
                                        input int unsigned                 n,
                                        input src_idx_t                    last);
      rr_pick_t    pick;
      int unsigned pos;
      pick = '0;
      for (int unsigned k = 1; k <= SWITCH_MAX_PORTS; k++) begin
         pos = 32'(last) + k;
         if (pos >= n) pos = pos - n;
         if (!pick.found && (k <= n) && cand[pos[SWITCH_IDX_W-1:0]]) begin
            pick.found = 1'b1;
            pick.idx   = pos[SWITCH_IDX_W-1:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/switch_rr_arbiter.sv
// Per-output round-robin arbiter: picks the next requesting input after the last winner,
// only when the output slot can accept a load.
module switch_rr_arbiter
   import switch_pkg::*;
#(
   parameter  int unsigned NUM_PORTS = SWITCH_DEF_PORTS,
   localparam int unsigned SRC_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] i_cand,
   input  logic [SRC_W-1:0]     i_rr_last,
   input  logic                 i_free,
   output logic [NUM_PORTS-1:0] o_gnt,
   output logic [SRC_W-1:0]     o_winner,
   output logic                 o_valid
);

   rr_pick_t w_pick;

   assign w_pick   = rr_scan(SWITCH_MAX_PORTS'(i_cand), NUM_PORTS, src_idx_t'(i_rr_last));
   assign o_valid  = i_free & w_pick.found;
   assign o_winner = SRC_W'(w_pick.idx);

   always_comb begin
      o_gnt = '0;
      if (o_valid) o_gnt[o_winner] = 1'b1;
   end

endmodule

// File: rtl/switch_xbar_arbiter.sv
// N-port crossbar arbitration core with unicast/multicast delivery and per-output registered slots.
// Define SWITCH_XBAR_STATS_EN to add the grant_cnt per-output delivery counters.
module switch_xbar_arbiter
   import switch_pkg::*;
#(
   parameter  int unsigned NUM_PORTS = SWITCH_DEF_PORTS,
   parameter  int unsigned DATA_W    = SWITCH_DEF_DATA_W,
   parameter  int unsigned CNT_W     = SWITCH_DEF_CNT_W,
   localparam int unsigned SRC_W     = $clog2(NUM_PORTS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PORTS-1:0]          req_valid,
   input  logic [NUM_PORTS*NUM_PORTS-1:0] req_target,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_data,
   output logic [NUM_PORTS-1:0]          req_ready,
   output logic [NUM_PORTS-1:0]          out_valid,
   output logic [NUM_PORTS*SRC_W-1:0]    out_source,
   output logic [NUM_PORTS*DATA_W-1:0]   out_data,
   input  logic [NUM_PORTS-1:0]          out_ready
`ifdef SWITCH_XBAR_STATS_EN
   ,
   output logic [NUM_PORTS*CNT_W-1:0]    grant_cnt
`endif
);

   if (NUM_PORTS < 2 || NUM_PORTS > SWITCH_MAX_PORTS || CNT_W == 0) begin : g_bad_cfg
      $error("switch_xbar_arbiter: unsupported NUM_PORTS or CNT_W");
   end

   logic [NUM_PORTS-1:0] w_target    [NUM_PORTS];
   logic [DATA_W-1:0]    w_data      [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_remaining [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_cand      [NUM_PORTS]; // per output, bit = input
   logic [NUM_PORTS-1:0] w_gnt_out   [NUM_PORTS]; // per output, bit = input
   logic [NUM_PORTS-1:0] w_gnt_in    [NUM_PORTS]; // per input, bit = output
   logic [SRC_W-1:0]     w_winner    [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_load;
   logic [NUM_PORTS-1:0] w_free;

   logic [NUM_PORTS-1:0] r_served     [NUM_PORTS];
   logic [NUM_PORTS-1:0] r_out_valid;
   logic [SRC_W-1:0]     r_out_source [NUM_PORTS];
   logic [DATA_W-1:0]    r_out_data   [NUM_PORTS];
   logic [SRC_W-1:0]     r_rr_last    [NUM_PORTS];

   always_comb begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         w_target[i]    = req_target[i*NUM_PORTS +: NUM_PORTS];
         w_data[i]      = req_data[i*DATA_W +: DATA_W];
         w_remaining[i] = w_target[i] & ~r_served[i];
      end
   end

   // A slot that drains this cycle can be reloaded in the same cycle.
   assign w_free = ~r_out_valid | out_ready;

   always_comb begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_cand[o][i] = req_valid[i] & w_remaining[i][o];
         end
      end
   end

   for (genvar go = 0; go < int'(NUM_PORTS); go++) begin : g_arb
      switch_rr_arbiter #(
         .NUM_PORTS (NUM_PORTS)
      ) u_arb (
         .i_cand    (w_cand[go]),
         .i_rr_last (r_rr_last[go]),
         .i_free    (w_free[go]),
         .o_gnt     (w_gnt_out[go]),
         .o_winner  (w_winner[go]),
         .o_valid   (w_load[go])
      );
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            w_gnt_in[i][o] = w_gnt_out[o][i];
         end
      end
   end

   // Consumed once every target has been delivered, including any granted this cycle.
   always_comb begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         req_ready[i] = req_valid[i] & ((w_remaining[i] & ~w_gnt_in[i]) == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= '0;
         for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            r_out_source[o] <= '0;
            r_out_data[o]   <= '0;
            r_rr_last[o]    <= SRC_W'(NUM_PORTS - 1);
            r_served[o]     <= '0;
         end
      end else begin
         for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (w_load[o]) begin
               r_out_valid[o]  <= 1'b1;
               r_out_source[o] <= w_winner[o];
               r_out_data[o]   <= w_data[w_winner[o]];
               r_rr_last[o]    <= w_winner[o];
            end else if (out_ready[o]) begin
               r_out_valid[o]  <= 1'b0;
            end
         end
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!req_valid[i] || req_ready[i]) r_served[i] <= '0;
            else                               r_served[i] <= r_served[i] | w_gnt_in[i];
         end
      end
   end

   always_comb begin
      out_valid = r_out_valid;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
         out_source[o*SRC_W +: SRC_W] = r_out_source[o];
         out_data[o*DATA_W +: DATA_W] = r_out_data[o];
      end
   end

`ifdef SWITCH_XBAR_STATS_EN
   logic [CNT_W-1:0] r_grant_cnt [NUM_PORTS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned o = 0; o < NUM_PORTS; o++) r_grant_cnt[o] <= '0;
      end else begin
         for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (w_load[o]) r_grant_cnt[o] <= r_grant_cnt[o] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) grant_cnt[o*CNT_W +: CNT_W] = r_grant_cnt[o];
   end
`else
   // Statistics disabled: no counter state is built.
`endif

endmodule

// File: tb/tb_switch_xbar_arbiter.sv
// Directed self-checking bench for switch_xbar_arbiter (4 ports, 16-bit data).
module tb_switch_xbar_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int SW = 2;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*N-1:0]  req_target;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    out_valid;
   logic [N*SW-1:0] out_source;
   logic [N*DW-1:0] out_data;
   logic [N-1:0]    out_ready;
`ifdef SWITCH_XBAR_STATS_EN
   logic [N*CW-1:0] grant_cnt;
`endif

   int n_checks;
   int n_errors;

   switch_xbar_arbiter #(
      .NUM_PORTS (N),
      .DATA_W    (DW),
      .CNT_W     (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_target (req_target),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_source (out_source),
      .out_data   (out_data),
      .out_ready  (out_ready)
`ifdef SWITCH_XBAR_STATS_EN
      ,
      .grant_cnt  (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [N-1:0] tgt,
                          input logic [DW-1:0] d);
      req_valid[i]          = v;
      req_target[i*N +: N]  = tgt;
      req_data[i*DW +: DW]  = d;
   endtask

   function automatic logic [31:0] src_of(input int o);
      return 32'(out_source[o*SW +: SW]);
   endfunction

   function automatic logic [31:0] dat_of(input int o);
      return 32'(out_data[o*DW +: DW]);
   endfunction

   int exp_w [6] = '{3, 0, 1, 3, 0, 1};

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst_n      = 1'b0;
      req_valid  = '0;
      req_target = '0;
      req_data   = '0;
      out_ready  = '1;
      #12;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_src", 32'(out_source), 32'h0);
      check("rst_data", out_data[31:0], 32'h0);
      rst_n = 1'b1;
      step();

      // Unicast
      set_req(1, 1'b1, 4'b0100, 16'hA5A5);
      #1 check("uc_ready", 32'(req_ready), 32'h2);
      step();
      set_req(1, 1'b0, 4'b0000, 16'h0);
      check("uc_valid", 32'(out_valid), 32'h4);
      check("uc_src", src_of(2), 32'd1);
      check("uc_data", dat_of(2), 32'hA5A5);
      step();
      check("uc_drain", 32'(out_valid), 32'h0);

      // Contention on output 2; last winner there was input 1
      for (int i = 0; i < N; i++) begin
         if (i != 2) set_req(i, 1'b1, 4'b0100, 16'(16'h1000 + i));
      end
      for (int k = 0; k < 6; k++) begin
         #1 check("ct_ready", 32'(req_ready), 32'(1 << exp_w[k]));
         step();
         check("ct_src", src_of(2), 32'(exp_w[k]));
         check("ct_data", dat_of(2), 32'(16'h1000 + exp_w[k]));
      end

      // Backpressure: slot 2 holds input 1's payload
      out_ready[2] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         check("bp_data", dat_of(2), 32'h1001);
         check("bp_ready", 32'(req_ready), 32'h0);
         step();
      end
      out_ready[2] = 1'b1;
      #1 check("bp_rel_ready", 32'(req_ready), 32'h8);
      step();
      check("bp_rel_src", src_of(2), 32'd3);
      check("bp_rel_data", dat_of(2), 32'h1003);
      req_valid = '0;
      step();
      check("bp_drain", 32'(out_valid), 32'h0);

      // Multicast with output 1 stalled
      out_ready = 4'b1101;
      set_req(2, 1'b1, 4'b0010, 16'h2222);
      step();
      set_req(2, 1'b0, 4'b0000, 16'h0);
      set_req(0, 1'b1, 4'b0011, 16'hBEEF);
      #1 check("mc_ready0", 32'(req_ready), 32'h0);
      step();
      check("mc_out0_valid", 32'(out_valid), 32'h3);
      check("mc_out0_src", src_of(0), 32'd0);
      check("mc_out0_data", dat_of(0), 32'hBEEF);
      check("mc_out1_hold", dat_of(1), 32'h2222);
      #1 check("mc_ready1", 32'(req_ready), 32'h0);
      step();
      check("mc_out0_drain", 32'(out_valid), 32'h2);
      out_ready[1] = 1'b1;
      #1 check("mc_ready2", 32'(req_ready), 32'h1);
      step();
      set_req(0, 1'b0, 4'b0000, 16'h0);
      check("mc_out1_valid", 32'(out_valid), 32'h2);
      check("mc_out1_src", src_of(1), 32'd0);
      check("mc_out1_data", dat_of(1), 32'hBEEF);
      step();
      check("mc_idle", 32'(out_valid), 32'h0);

      // Zero target mask
      out_ready = '1;
      set_req(3, 1'b1, 4'b0000, 16'hDEAD);
      #1 check("zm_ready", 32'(req_ready), 32'h8);
      step();
      set_req(3, 1'b0, 4'b0000, 16'h0);
      check("zm_valid", 32'(out_valid), 32'h0);

      // Asynchronous reset with slot 2 full
      set_req(0, 1'b1, 4'b0100, 16'h7777);
      step();
      set_req(0, 1'b0, 4'b0000, 16'h0);
      out_ready[2] = 1'b0;
      check("mid_pre", 32'(out_valid), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      check("mid_async_valid", 32'(out_valid), 32'h0);
      check("mid_async_data", dat_of(2), 32'h0);
      #2 rst_n = 1'b1;
      out_ready = '1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'b0001, 16'(16'h4000 + i));
      #1 check("mid_rr_ready", 32'(req_ready), 32'h1);
      step();
      check("mid_rr_src", src_of(0), 32'd0);
      check("mid_rr_data", dat_of(0), 32'h4000);
      req_valid = '0;
      step();

`ifdef SWITCH_XBAR_STATS_EN
      check("cnt3_zero", 32'(grant_cnt[3*CW +: CW]), 32'd0);
      set_req(1, 1'b1, 4'b1000, 16'h5555);
      for (int c = 0; c < 5; c++) step();
      set_req(1, 1'b0, 4'b0000, 16'h0);
      step();
      check("cnt3_five", 32'(grant_cnt[3*CW +: CW]), 32'd5);
      check("cnt0_one", 32'(grant_cnt[0 +: CW]), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
